// File: rtl/param_sp_ram_pkg.sv
// -----------------------------------------------------------------------------
// param_sp_ram_pkg
// Shared types and helpers for the parametrised single-port RAM.
//   state_e      : controller state (clearing after reset, or serving traffic)
//   MODE_WR/RD   : encoding of the 'mode' request input
//   even_parity  : even parity bit over a word of up to 64 bits
//                  (narrower words are zero-extended, which does not change
//                  the parity)
// -----------------------------------------------------------------------------
package param_sp_ram_pkg;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_e;

  localparam logic MODE_WR = 1'b0;
  localparam logic MODE_RD = 1'b1;

  // Parity bit that makes the total number of ones (word + bit) even.
  function automatic logic even_parity(input logic [63:0] i_word);
    return ^i_word;
  endfunction

endpackage

// File: rtl/param_sp_ram_rd_pipe.sv
// -----------------------------------------------------------------------------
// param_sp_ram_rd_pipe
// RD_LAT-deep delay line for the read response {valid, data, err}.
// The final stage is the output register: data only loads on a valid read, so
// the output holds the last read word; err is forced low unless valid.
// An optional front stage is added when RD_LAT == 2 (any other value behaves
// as latency 1).
// Ports:
//   i_clk      clock, rising edge
//   i_flush_n  synchronous active-low flush, clears every stage
//   i_valid    read accepted this cycle
//   i_data     word read from the array
//   i_err      parity mismatch for i_data
//   o_valid    one-cycle pulse per completed read
//   o_data     registered read data (holds between reads)
//   o_err      registered parity error, only meaningful with o_valid
// -----------------------------------------------------------------------------
module param_sp_ram_rd_pipe #(
  parameter int DATA_W = 8,
  parameter int RD_LAT = 1
) (
  input  logic              i_clk,
  input  logic              i_flush_n,
  input  logic              i_valid,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_err,
  output logic              o_valid,
  output logic [DATA_W-1:0] o_data,
  output logic              o_err
);

  logic              w_valid;
  logic [DATA_W-1:0] w_data;
  logic              w_err;

  logic              r_out_valid;
  logic [DATA_W-1:0] r_out_data;
  logic              r_out_err;

  generate
    if (RD_LAT == 2) begin : g_lat2
      logic              r_valid;
      logic [DATA_W-1:0] r_data;
      logic              r_err;

      // Extra delay stage in front of the output register.
      always_ff @(posedge i_clk) begin
        if (!i_flush_n) begin
          r_valid <= 1'b0;
          r_data  <= '0;
          r_err   <= 1'b0;
        end else begin
          r_valid <= i_valid;
          r_data  <= i_data;
          r_err   <= i_err;
        end
      end

      assign w_valid = r_valid;
      assign w_data  = r_data;
      assign w_err   = r_err;
    end else begin : g_lat1
      assign w_valid = i_valid;
      assign w_data  = i_data;
      assign w_err   = i_err;
    end
  endgenerate

  // Output register: data holds between reads, valid/err are single pulses.
  always_ff @(posedge i_clk) begin
    if (!i_flush_n) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_err   <= 1'b0;
    end else begin
      r_out_valid <= w_valid;
      r_out_err   <= w_valid & w_err;
      if (w_valid) begin
        r_out_data <= w_data;
      end
    end
  end

  assign o_valid = r_out_valid;
  assign o_data  = r_out_data;
  assign o_err   = r_out_err;

endmodule

// File: rtl/param_sp_ram.sv
// -----------------------------------------------------------------------------
// param_sp_ram
// Parametrised single-port synchronous RAM with req/ready handshake and a
// read latency of 1 or 2 cycles. After every reset a clear sequence writes
// INIT_VAL to each word (one word per cycle) before 'ready' rises.
// Optional feature macro: PARAM_SP_RAM_PARITY_EN
//   defined   : one even-parity bit stored per word, checked on read, reported
//               on rd_err together with dout_valid
//   undefined : no parity storage, rd_err is constant 0
// Ports:
//   clock       single clock, rising edge
//   rst         synchronous reset, active-low
//   req         access request, accepted when ready=1
//   mode        0 = write, 1 = read
//   addr        word address
//   din         write data
//   ready       1 = accepting requests
//   dout        registered read data, holds the last read word
//   dout_valid  one-cycle pulse per completed read
//   rd_err      read parity error, qualified by dout_valid
// -----------------------------------------------------------------------------
module param_sp_ram
  import param_sp_ram_pkg::*;
#(
  parameter int                DATA_W   = 8,
  parameter int                ADDR_W   = 3,
  parameter int                RD_LAT   = 1,
  parameter logic [DATA_W-1:0] INIT_VAL = '0
) (
  input  logic              clock,
  input  logic              rst,
  input  logic              req,
  input  logic              mode,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] din,
  output logic              ready,
  output logic [DATA_W-1:0] dout,
  output logic              dout_valid,
  output logic              rd_err
);

  localparam int DEPTH = 2 ** ADDR_W;
  // Counter is one bit wider than the address so the last word is unambiguous.
  localparam logic [ADDR_W:0] CLR_LAST = (ADDR_W + 1)'(DEPTH - 1);

  state_e            r_state;
  state_e            w_state_nxt;
  logic [ADDR_W:0]   r_clr_cnt;
  logic [ADDR_W:0]   w_clr_cnt_nxt;
  logic              r_ready;
  logic              w_ready_nxt;

  logic [DATA_W-1:0] r_mem [DEPTH];

  logic              w_clr_we;
  logic              w_acc;
  logic              w_wr_acc;
  logic              w_rd_acc;
  logic [DATA_W-1:0] w_rd_data;
  logic              w_rd_err;

  // Next-state logic for the clear/run controller.
  always_comb begin
    w_state_nxt   = r_state;
    w_clr_cnt_nxt = r_clr_cnt;
    w_ready_nxt   = r_ready;
    case (r_state)
      ST_CLEAR: begin
        w_clr_cnt_nxt = r_clr_cnt + (ADDR_W + 1)'(1);
        if (r_clr_cnt == CLR_LAST) begin
          w_state_nxt = ST_RUN;
          w_ready_nxt = 1'b1;
        end else begin
          w_ready_nxt = 1'b0;
        end
      end
      ST_RUN: begin
        w_ready_nxt = 1'b1;
      end
      default: begin
        w_state_nxt   = ST_CLEAR;
        w_clr_cnt_nxt = '0;
        w_ready_nxt   = 1'b0;
      end
    endcase
  end

  // Controller state registers; reset always restarts the clear from word 0.
  always_ff @(posedge clock) begin
    if (!rst) begin
      r_state   <= ST_CLEAR;
      r_clr_cnt <= '0;
      r_ready   <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_clr_cnt <= w_clr_cnt_nxt;
      r_ready   <= w_ready_nxt;
    end
  end

  // Everything is gated with rst so the array is untouched while in reset.
  assign w_clr_we  = rst && (r_state == ST_CLEAR);
  assign w_acc     = rst && req && r_ready;
  assign w_wr_acc  = w_acc && (mode == MODE_WR);
  assign w_rd_acc  = w_acc && (mode == MODE_RD);
  assign w_rd_data = r_mem[addr];

  // Storage array: clear has priority, though ready=0 already excludes writes.
  always_ff @(posedge clock) begin
    if (w_clr_we) begin
      r_mem[r_clr_cnt[ADDR_W-1:0]] <= INIT_VAL;
    end else if (w_wr_acc) begin
      r_mem[addr] <= din;
    end
  end

`ifdef PARAM_SP_RAM_PARITY_EN
  logic r_par [DEPTH];

  // Parity column, written in lockstep with the data array.
  always_ff @(posedge clock) begin
    if (w_clr_we) begin
      r_par[r_clr_cnt[ADDR_W-1:0]] <= even_parity(64'(INIT_VAL));
    end else if (w_wr_acc) begin
      r_par[addr] <= even_parity(64'(din));
    end
  end

  // Recompute parity over the stored word and compare with the stored bit.
  always_comb begin
    if (w_rd_acc) begin
      w_rd_err = (even_parity(64'(w_rd_data)) != r_par[addr]);
    end else begin
      w_rd_err = 1'b0;
    end
  end
`else
  assign w_rd_err = 1'b0;
`endif

  param_sp_ram_rd_pipe #(
    .DATA_W (DATA_W),
    .RD_LAT (RD_LAT)
  ) u_rd_pipe (
    .i_clk     (clock),
    .i_flush_n (rst),
    .i_valid   (w_rd_acc),
    .i_data    (w_rd_data),
    .i_err     (w_rd_err),
    .o_valid   (dout_valid),
    .o_data    (dout),
    .o_err     (rd_err)
  );

  assign ready = r_ready;

endmodule
